// File: rtl/translation_pkg.sv
// Shared TLB types and address helpers for tlb_unit and tlb_match.
// Lookup result formatting lives here so the fetch and data ports decode identically.
package translation_pkg;

   localparam int NUM_TLB   = 16;
   localparam int TLB_INDEX = 4;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] index;
      logic [31:0] entryhi;
      logic [31:0] entrylo0;
      logic [31:0] entrylo1;
   } tu_op_resp_t;

   typedef struct packed {
      logic [31:0] pa;
      logic        uncached;
      logic        refill;
      logic        invalid;
      logic        modified;
   } tlb_lookup_t;

   typedef enum logic [1:0] {SEG_MAPPED, SEG_KSEG0, SEG_KSEG1} seg_t;

   function automatic seg_t seg_decode(input logic [31:0] va);
      if (va[31:29] == 3'b100)
         return SEG_KSEG0;
      else if (va[31:29] == 3'b101)
         return SEG_KSEG1;
      else
         return SEG_MAPPED;
   endfunction

   // Faults are exclusive and ordered refill > invalid > mod; any fault zeroes pa.
   function automatic tlb_lookup_t format_lookup(input logic [31:0] va,
                                                 input logic        store,
                                                 input logic        hit,
                                                 input tlb_entry_t  e,
                                                 input logic [2:0]  k0);
      tlb_lookup_t r;
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
      r   = '0;
      pfn = va[12] ? e.pfn1 : e.pfn0;
      c   = va[12] ? e.c1   : e.c0;
      d   = va[12] ? e.d1   : e.d0;
      v   = va[12] ? e.v1   : e.v0;
      case (seg_decode(va))
         SEG_KSEG0: begin
            r.pa       = va & 32'h1FFF_FFFF;
            r.uncached = (k0 != 3'd3);
         end
         SEG_KSEG1: begin
            r.pa       = va & 32'h1FFF_FFFF;
            r.uncached = 1'b1;
         end
         default: begin
            if (!hit)
               r.refill = 1'b1;
            else if (!v)
               r.invalid = 1'b1;
            else if (store && !d)
               r.modified = 1'b1;
            else begin
               r.pa       = {pfn, va[11:0]};
               r.uncached = (c != 3'd3);
            end
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational fully associative match over the TLB array.
// The scan runs from the top index down so the lowest matching index is the one kept.
module tlb_match
   import translation_pkg::*;
(
   input  tlb_entry_t [NUM_TLB-1:0] entries,
   input  logic [18:0]              vpn2,
   input  logic [7:0]               asid,
   output logic                     hit,
   output logic [TLB_INDEX-1:0]     idx,
   output tlb_entry_t               entry
);

   always_comb begin
      hit   = 1'b0;
      idx   = '0;
      entry = '0;
      for (int i = NUM_TLB - 1; i >= 0; i--) begin
         if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
            hit   = 1'b1;
            idx   = TLB_INDEX'(i);
            entry = entries[i];
         end
      end
   end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: CP0 probe/read/write service, Random counter and 1-cycle fetch/data translation.
// Probe and read are combinational; writes land on the clock edge, so same-cycle users see old contents.
module tlb_unit
   import translation_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          entryhi,
   input  logic [31:0]          entrylo0,
   input  logic [31:0]          entrylo1,
   input  logic [31:0]          index,
   input  logic [TLB_INDEX-1:0] wired,
   input  logic                 wired_we,
   input  logic [2:0]           k0,
   input  logic                 is_tlbwi,
   input  logic                 is_tlbwr,
   output tu_op_resp_t          tu_op_resp,
   output logic [TLB_INDEX-1:0] random,
   input  logic                 i_req,
   input  logic [31:0]          i_va,
   output logic                 i_resp,
   output logic [31:0]          i_pa,
   output logic                 i_uncached,
   output logic                 i_refill,
   output logic                 i_invalid,
   input  logic                 d_req,
   input  logic [31:0]          d_va,
   input  logic                 d_store,
   output logic                 d_resp,
   output logic [31:0]          d_pa,
   output logic                 d_uncached,
   output logic                 d_refill,
   output logic                 d_invalid,
   output logic                 d_mod
);

   localparam logic [TLB_INDEX-1:0] RAND_TOP = TLB_INDEX'(NUM_TLB - 1);

   tlb_entry_t [NUM_TLB-1:0] tlb_q;
   tlb_entry_t               wr_entry;
   tlb_entry_t               rd_entry;
   logic [TLB_INDEX-1:0]     random_q;
   logic [TLB_INDEX-1:0]     waddr;

   logic                     i_resp_q, d_resp_q, d_store_q;
   logic [31:0]              i_va_q, d_va_q;
   logic [7:0]               i_asid_q, d_asid_q;
   tlb_lookup_t              i_lk, d_lk, i_hold_q, d_hold_q, i_out, d_out;

   logic                     i_hit, d_hit, p_hit;
   logic [TLB_INDEX-1:0]     p_idx, i_idx_unused, d_idx_unused;
   tlb_entry_t               i_entry, d_entry, p_entry_unused;

   always_comb begin
      wr_entry      = '0;
      wr_entry.vpn2 = entryhi[31:13];
      wr_entry.asid = entryhi[7:0];
      wr_entry.g    = entrylo0[0] & entrylo1[0];
      wr_entry.pfn0 = entrylo0[25:6];
      wr_entry.c0   = entrylo0[5:3];
      wr_entry.d0   = entrylo0[2];
      wr_entry.v0   = entrylo0[1];
      wr_entry.pfn1 = entrylo1[25:6];
      wr_entry.c1   = entrylo1[5:3];
      wr_entry.d1   = entrylo1[2];
      wr_entry.v1   = entrylo1[1];
   end

   assign waddr = is_tlbwi ? index[TLB_INDEX-1:0] : random_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         tlb_q <= '0;
      else if (is_tlbwi || is_tlbwr)
         tlb_q[waddr] <= wr_entry;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         random_q <= RAND_TOP;
      else if (wired_we || random_q <= wired)
         random_q <= RAND_TOP;
      else
         random_q <= random_q - 1'b1;
   end

   assign random = random_q;

   tlb_match u_match_p (
      .entries (tlb_q),
      .vpn2    (entryhi[31:13]),
      .asid    (entryhi[7:0]),
      .hit     (p_hit),
      .idx     (p_idx),
      .entry   (p_entry_unused)
   );

   assign rd_entry = tlb_q[index[TLB_INDEX-1:0]];

   always_comb begin
      tu_op_resp          = '0;
      tu_op_resp.index    = p_hit ? {{(32 - TLB_INDEX){1'b0}}, p_idx} : 32'h8000_0000;
      tu_op_resp.entryhi  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
      tu_op_resp.entrylo0 = {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
      tu_op_resp.entrylo1 = {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
   end

   // Lookup requests carry the current ASID along with the address.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_resp_q  <= 1'b0;
         i_va_q    <= '0;
         i_asid_q  <= '0;
         d_resp_q  <= 1'b0;
         d_va_q    <= '0;
         d_asid_q  <= '0;
         d_store_q <= 1'b0;
      end else begin
         i_resp_q <= i_req;
         d_resp_q <= d_req;
         if (i_req) begin
            i_va_q   <= i_va;
            i_asid_q <= entryhi[7:0];
         end
         if (d_req) begin
            d_va_q    <= d_va;
            d_asid_q  <= entryhi[7:0];
            d_store_q <= d_store;
         end
      end
   end

   tlb_match u_match_i (
      .entries (tlb_q),
      .vpn2    (i_va_q[31:13]),
      .asid    (i_asid_q),
      .hit     (i_hit),
      .idx     (i_idx_unused),
      .entry   (i_entry)
   );

   tlb_match u_match_d (
      .entries (tlb_q),
      .vpn2    (d_va_q[31:13]),
      .asid    (d_asid_q),
      .hit     (d_hit),
      .idx     (d_idx_unused),
      .entry   (d_entry)
   );

   assign i_lk = format_lookup(i_va_q, 1'b0, i_hit, i_entry, k0);
   assign d_lk = format_lookup(d_va_q, d_store_q, d_hit, d_entry, k0);

   // Results reflect the array in the response cycle, then freeze until the next request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_hold_q <= '0;
         d_hold_q <= '0;
      end else begin
         if (i_resp_q)
            i_hold_q <= i_lk;
         if (d_resp_q)
            d_hold_q <= d_lk;
      end
   end

   assign i_out = i_resp_q ? i_lk : i_hold_q;
   assign d_out = d_resp_q ? d_lk : d_hold_q;

   assign i_resp     = i_resp_q;
   assign i_pa       = i_out.pa;
   assign i_uncached = i_out.uncached;
   assign i_refill   = i_out.refill;
   assign i_invalid  = i_out.invalid;

   assign d_resp     = d_resp_q;
   assign d_pa       = d_out.pa;
   assign d_uncached = d_out.uncached;
   assign d_refill   = d_out.refill;
   assign d_invalid  = d_out.invalid;
   assign d_mod      = d_out.modified;

   logic unused_bits;
   assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26], index[31:TLB_INDEX],
                          i_out.modified, i_idx_unused, d_idx_unused, p_entry_unused};

endmodule
